instruction_fetch: RTL

- Front-end stage directly upstream of instruction_decoder.
- Maintains the fetch PC and issues word requests to instruction memory.
- Buffers returned words in a small in-order queue and presents {instruction, pc} to the decoder with a valid/ready handshake.
- Supports a one-cycle redirect (branch/jump/trap) that flushes everything in flight.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions.
// Holds the machine word width, the canonical NOP encoding, the default reset
// PC, the base opcode map used by both instruction_fetch and
// instruction_decoder, and the fetch queue entry layout.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Base opcode map (instr[6:0])
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // One buffered fetch result as handed to the decoder.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with registered storage.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        empties the queue; dominates push and pop
//   push/push_data  write one entry (caller guarantees no overflow)
//   pop          drop the head entry; ignored while empty
//   count/empty/full  occupancy status
//   head         current head entry (undefined while empty)
// Push and pop in the same cycle are legal at any occupancy, including full.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign push_en = push & ~flush & ~reset;
  assign pop_en  = pop & ~empty & ~flush & ~reset;

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + 1'b1;
    end else if (!push_en && pop_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // When full, the write slot equals the head slot being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end.
// Keeps the fetch PC, issues word requests to instruction memory under a
// credit limit (buffered + outstanding <= DEPTH), buffers responses in order and
// hands {instruction, inst_pc} to the decoder with a valid/ready handshake.
// A single-cycle redirect reloads the PC, flushes the buffer and arranges for
// every response still in flight to be discarded.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt         request channel (handshake = req & gnt)
//   imem_rvalid/imem_rdata              in-order response channel
//   redirect_valid/redirect_pc          PC redirect (bits [1:0] ignored)
//   inst_valid/inst_ready               decoder handshake
//   instruction/inst_pc                 queue head word and its PC
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned INF_W = CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] inst_count, outstanding;
  logic             inst_empty, inst_full, tag_empty, tag_full;
  logic [31:0]      tag_head;
  fetch_entry_t     push_entry, head_entry;
  logic [INF_W-1:0] inflight;
  logic             handshake, resp_keep, pop;

  // Credit check uses registered occupancy only, so imem_req has no path from gnt/rvalid.
  assign inflight  = {1'b0, inst_count} + {1'b0, outstanding};
  assign imem_req  = ~reset & ~redirect_valid & (inflight < INF_W'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign handshake = imem_req & imem_gnt;

  // Responses are dropped while stale ones drain, and in the redirect cycle itself.
  assign resp_keep = imem_rvalid & (drop_cnt_q == '0) & ~redirect_valid;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = tag_head;

  assign inst_valid  = ~inst_empty;
  assign pop         = inst_valid & inst_ready;
  assign instruction = inst_valid ? head_entry.instr : NOP_INSTR;
  assign inst_pc     = inst_valid ? head_entry.pc : 32'h0;

  // PC of every outstanding request, in issue order. Never flushed by a redirect:
  // its occupancy is the outstanding count, and dropped responses still pop it.
  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (handshake),
    .push_data (fetch_pc_q),
    .pop       (imem_rvalid),
    .count     (outstanding),
    .empty     (tag_empty),
    .full      (tag_full),
    .head      (tag_head)
  );

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .count     (inst_count),
    .empty     (inst_empty),
    .full      (inst_full),
    .head      (head_entry)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      // No request issues this cycle; everything left after it is stale.
      drop_cnt_d = outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (handshake) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    inst_count <= CNT_W'(DEPTH));
  a_credit_bound : assert property (@(posedge clk) disable iff (reset)
    inflight <= INF_W'(DEPTH));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> !tag_empty);
  a_no_tag_overflow : assert property (@(posedge clk) disable iff (reset)
    handshake |-> !tag_full);
  a_no_inst_overflow : assert property (@(posedge clk) disable iff (reset)
    (resp_keep && inst_full) |-> pop);
  a_addr_aligned : assert property (@(posedge clk) disable iff (reset)
    imem_addr[1:0] == 2'b00);

endmodule
